// File: rtl/exmem_pkg.sv
// Shared types and constants for the execute/memory stage.
package exmem_pkg;

  localparam logic [2:0] ALUCTR_ADD = 3'd0;
  localparam logic [2:0] ALUCTR_SUB = 3'd1;
  localparam logic [2:0] ALUCTR_SLT = 3'd2;

  localparam logic [2:0] CMP_NONE = 3'd0;
  localparam logic [2:0] CMP_BEQ  = 3'd1;

  localparam int DMEM_DEPTH = 256;
  localparam int DMEM_AW    = $clog2(DMEM_DEPTH);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_LOAD = 1'b1
  } state_e;

endpackage

// File: rtl/exmem_alu.sv
// Combinational ALU: add/sub/signed-slt result, raw sum for addressing, equality for beq.
module exmem_alu
  import exmem_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] cmp_i,
  input  logic [2:0]  aluctr_i,
  output logic [31:0] sum_o,
  output logic [31:0] result_o,
  output logic        eq_o
);

  assign sum_o = a_i + b_i;
  assign eq_o  = (a_i == cmp_i);

  // Undefined opcodes fall through to add.
  always_comb begin
    case (aluctr_i)
      ALUCTR_SUB: result_o = a_i - b_i;
      ALUCTR_SLT: result_o = {31'd0, $signed(a_i) < $signed(b_i)};
      default:    result_o = sum_o;
    endcase
  end

endmodule

// File: rtl/exec_mem_stage.sv
// Execute/memory stage: 1-cycle ALU ops, stores, 2-cycle loads through IDLE/LOAD FSM.
// Branch resolution is built only when EXMEM_BRANCH_EN is defined.
module exec_mem_stage
  import exmem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        dx_valid,
  input  logic [31:0] dx_a,
  input  logic [31:0] dx_b,
  input  logic [31:0] dx_sd,
  input  logic [4:0]  dx_rd,
  input  logic [2:0]  dx_aluctr,
  input  logic        dx_lw,
  input  logic        dx_sw,
  input  logic [2:0]  dx_cmp,
  input  logic [31:0] dx_pc,
  output logic        mw_valid,
  output logic [4:0]  mw_rd,
  output logic [31:0] mw_aluout,
  output logic [2:0]  mw_cmp,
  output logic        stall,
  output logic        br_taken,
  output logic [31:0] br_target
);

  state_e              state_q, state_d;
  logic                mw_valid_q, mw_valid_d;
  logic [4:0]          mw_rd_q, mw_rd_d;
  logic [31:0]         mw_aluout_q, mw_aluout_d;
  logic [2:0]          mw_cmp_q, mw_cmp_d;
  logic                br_taken_q, br_taken_d;
  logic [31:0]         br_target_q, br_target_d;
  logic [DMEM_AW-1:0]  ld_idx_q, ld_idx_d;
  logic [4:0]          ld_rd_q, ld_rd_d;
  logic                mem_we;

  logic [31:0] addr, alu_res;
  logic        eq;
  logic [31:0] mem_q [DMEM_DEPTH];

  exmem_alu u_alu (
    .a_i      (dx_a),
    .b_i      (dx_b),
    .cmp_i    (dx_sd),
    .aluctr_i (dx_aluctr),
    .sum_o    (addr),
    .result_o (alu_res),
    .eq_o     (eq)
  );

  logic unused_addr;
  assign unused_addr = ^{addr[31:DMEM_AW+2], addr[1:0]};

`ifndef EXMEM_BRANCH_EN
  logic unused_br;
  assign unused_br = ^{eq, dx_pc};
`endif

  always_comb begin
    state_d     = state_q;
    mw_valid_d  = 1'b0;
    mw_rd_d     = 5'd0;
    mw_aluout_d = 32'd0;
    mw_cmp_d    = CMP_NONE;
    br_taken_d  = 1'b0;
    br_target_d = 32'd0;
    ld_idx_d    = ld_idx_q;
    ld_rd_d     = ld_rd_q;
    mem_we      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (dx_valid) begin
          mw_cmp_d = dx_cmp;
          // lw wins over sw so a malformed lw+sw never touches memory.
          if (dx_lw) begin
            state_d  = S_LOAD;
            ld_idx_d = addr[DMEM_AW+1:2];
            ld_rd_d  = dx_rd;
          end else if (dx_sw) begin
            mem_we     = 1'b1;
            mw_valid_d = 1'b1;
          end else if (dx_cmp == CMP_BEQ) begin
            mw_valid_d = 1'b1;
`ifdef EXMEM_BRANCH_EN
            br_taken_d  = eq;
            br_target_d = dx_pc + 32'd4 + {dx_b[29:0], 2'b00};
`endif
          end else begin
            mw_valid_d  = 1'b1;
            mw_rd_d     = dx_rd;
            mw_aluout_d = alu_res;
          end
        end
      end
      S_LOAD: begin
        state_d     = S_IDLE;
        mw_valid_d  = 1'b1;
        mw_rd_d     = ld_rd_q;
        mw_aluout_d = mem_q[ld_idx_q];
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mw_valid_q  <= 1'b0;
      mw_rd_q     <= 5'd0;
      mw_aluout_q <= 32'd0;
      mw_cmp_q    <= CMP_NONE;
      br_taken_q  <= 1'b0;
      br_target_q <= 32'd0;
      ld_idx_q    <= '0;
      ld_rd_q     <= 5'd0;
    end else begin
      state_q     <= state_d;
      mw_valid_q  <= mw_valid_d;
      mw_rd_q     <= mw_rd_d;
      mw_aluout_q <= mw_aluout_d;
      mw_cmp_q    <= mw_cmp_d;
      br_taken_q  <= br_taken_d;
      br_target_q <= br_target_d;
      ld_idx_q    <= ld_idx_d;
      ld_rd_q     <= ld_rd_d;
    end
  end

  // Data memory keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[addr[DMEM_AW+1:2]] <= dx_sd;
  end

  assign stall     = (state_q == S_LOAD);
  assign mw_valid  = mw_valid_q;
  assign mw_rd     = mw_rd_q;
  assign mw_aluout = mw_aluout_q;
  assign mw_cmp    = mw_cmp_q;
  assign br_taken  = br_taken_q;
  assign br_target = br_target_q;

endmodule

// File: doc/exec_mem_stage.md
EXEC_MEM_STAGE -- requirements
Module: exec_mem_stage

Interface
REQ-001 SHALL have port clk, input, 1, clock; all state rising-edge.
REQ-002 SHALL have port rst, input, 1; reset is asynchronous, active-high; clock is clk.
REQ-003 SHALL have port dx_valid, input, 1, decode-stage instruction present.
REQ-004 SHALL have ports dx_a and dx_b, input, 32 each, ALU operands; dx_b is the immediate or branch offset for lw/sw/beq.
REQ-005 SHALL have port dx_sd, input, 32, rt register value: store data for sw, compare operand for beq.
REQ-006 SHALL have port dx_rd, input, 5, destination register.
REQ-007 SHALL have port dx_aluctr, input, 3, ALU op: 0=add, 1=sub, 2=slt/compare.
REQ-008 SHALL have ports dx_lw and dx_sw, input, 1 each; and dx_cmp, input, 3, with 0=none and 1=beq.
REQ-009 SHALL have port dx_pc, input, 32, address of the instruction.
REQ-010 SHALL have port mw_valid, output, 1, write-back slot valid.
REQ-011 SHALL have ports mw_rd, output, 5, and mw_aluout, output, 32, write-back register and data.
REQ-012 SHALL have port mw_cmp, output, 3, registered copy of dx_cmp.
REQ-013 SHALL have port stall, output, 1; upstream holds all dx_* while it is high.
REQ-014 SHALL have ports br_taken, output, 1, and br_target, output, 32, branch redirect.

Function
REQ-015 SHALL contain a 256x32 data memory, word index addr[9:2]; addr = dx_a + dx_b mod 2^32; addr[1:0] ignored.
REQ-016 SHALL implement FSM IDLE/LOAD; IDLE accepts dx_* when dx_valid=1.
REQ-017 SHALL, in IDLE, take add/sub/slt (dx_lw=dx_sw=0, dx_cmp=0) with 1-cycle latency: next edge mw_valid=1, mw_rd=dx_rd, mw_aluout=result.
REQ-018 SHALL compute add/sub modulo 2^32; slt is signed and yields 32'd1 or 32'd0.
REQ-019 SHALL, on sw in IDLE, write dx_sd to the memory at the edge; mw_valid=1, mw_rd=0.
REQ-020 SHALL, on lw in IDLE, go to LOAD, latch the address and dx_rd, and hold stall=1 throughout LOAD.
REQ-021 SHALL, in LOAD, ignore dx_*; the next edge returns to IDLE with mw_valid=1, mw_rd=latched rd, mw_aluout=mem[latched index]. Load latency is 2 cycles.
REQ-022 SHALL, on beq with dx_cmp=1, set br_taken=1 for exactly one cycle when dx_a==dx_sd; br_target=dx_pc+4+(dx_b<<2) mod 2^32; mw_rd=0.
REQ-023 SHALL drive stall=0 in IDLE; stall SHALL be a decode of the state register.
REQ-024 SHALL force mw_rd=0 and mw_aluout=0 whenever mw_valid=0; dx_valid=0 in IDLE yields mw_valid=0 next cycle.
REQ-025 SHALL treat dx_lw=dx_sw=1 as lw; no memory write occurs.
REQ-026 SHALL treat an undefined dx_aluctr (3-7) as add.

Reset
REQ-027 SHALL, on rst, clear the state to IDLE and set mw_valid, mw_rd, mw_aluout, mw_cmp, br_taken, br_target and stall to 0.
REQ-028 SHALL, on rst asserted during LOAD, discard the pending load and produce no write-back.
REQ-029 SHALL NOT reset the memory contents.

Configuration
REQ-030 SHALL, with EXMEM_BRANCH_EN defined, implement REQ-022.
REQ-031 SHALL, without EXMEM_BRANCH_EN, tie br_taken=0 and br_target=0 and treat beq as a no-op with mw_valid=1 and mw_rd=0.

Structure
REQ-032 SHALL place ALUCTR_ADD/SUB/SLT, CMP_NONE/CMP_BEQ, the FSM state enum and DMEM_DEPTH=256 in shared package exmem_pkg.
REQ-033 SHALL put the combinational ALU (add/sub/slt/equal) in sub-module exmem_alu.

Verification
REQ-034 SHALL test add: dx_a=5, dx_b=7, dx_rd=3, dx_aluctr=0 -> next cycle mw_valid=1, mw_rd=3, mw_aluout=12.
REQ-035 SHALL test slt: dx_a=32'hFFFFFFFF, dx_b=1, dx_aluctr=2 -> mw_aluout=1; sub 3-5 -> 32'hFFFFFFFE.
REQ-036 SHALL test sw then lw: sw with dx_a=16, dx_b=4, dx_sd=32'hDEADBEEF; then lw with the same address and dx_rd=9 -> stall=1 for one cycle, then mw_rd=9, mw_aluout=32'hDEADBEEF.
REQ-037 SHALL test beq: dx_pc=32'h100, dx_a=dx_sd=7, dx_b=32'hFFFFFFFE -> br_taken=1 for one cycle, br_target=32'hFC; with dx_sd=8 -> br_taken=0.
REQ-038 SHALL test rst asserted in LOAD -> stall=0, mw_valid=0 immediately; the following add behaves per REQ-017.
REQ-039 SHALL test dx_lw=dx_sw=1 -> memory unchanged (read back to confirm) and load data returned.
